// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_pkg
//  Brief    : Shared types, constants and helpers for the bit-serial
//             N-bit subtractor.
//  Revision : 1.0  initial release
// ============================================================================
package serial_sub_pkg;

    // Operand width used when the top level is not overridden
    localparam int DEFAULT_WIDTH = 4;

    // Sequencer states: accept operands, shift bits through the cell,
    // then hold the result until the consumer takes it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width, wide enough to hold the value WIDTH itself
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor
//  Brief    : Combinational 1-bit full subtractor, d = a - b - bin with
//             borrow-out.
//  Revision : 1.0  initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow: borrow when a<b, or when a==b and a
    // borrow is already pending
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule
`default_nettype wire

// File: rtl/serial_sub_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_nbit
//  Brief    : Bit-serial WIDTH-bit subtractor, DIFF = A - B - BIN, one bit
//             per cycle LSB first, valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module serial_sub_nbit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  diff_q;
    logic              borrow;
    logic              bout_q;
    logic [CW-1:0]     cnt;

    logic              cell_d;
    logic              cell_bout;

    // Single shared arithmetic cell fed from the operand LSBs
    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Handshake flags come from the state register alone, so there is no
    // combinational path from IN_VALID or OUT_READY
    always_comb begin
        IN_READY  = (state == IDLE);
        OUT_VALID = (state == DONE);
        DIFF      = diff_q;
        BOUT      = bout_q;
    end

    // Sequencer, operand shifters, borrow chain and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            borrow <= 1'b0;
            bout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= BIN;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    diff_q <= {cell_d, diff_q[WIDTH-1:1]};
                    borrow <= cell_bout;
                    cnt    <= cnt + 1'b1;
                    // Final bit: latch the outgoing borrow as BOUT
                    if (cnt == LAST_BIT) begin
                        bout_q <= cell_bout;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub_nbit
//  Brief    : Directed and exhaustive self-checking bench for
//             serial_sub_nbit (WIDTH = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_sub_nbit;

    localparam int WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BIN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] DIFF;
    logic             BOUT;

    int passed = 0;
    int total  = 0;

    serial_sub_nbit #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .BIN       (BIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DIFF      (DIFF),
        .BOUT      (BOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one operand set with OUT_READY high, check latency and result,
    // then check the block is back in IDLE after the handoff
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic bin, input logic [3:0] exp_d, input logic exp_b);
        int n;
        @(negedge CLK);
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        A = a; B = b; BIN = bin;
        check({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
        @(negedge CLK);
        IN_VALID = 1'b0;
        A = ~a; B = ~b; BIN = ~bin;
        n = 0;
        while (!OUT_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        check({tag, "_diff"}, 32'(DIFF), 32'(exp_d));
        check({tag, "_bout"}, 32'(BOUT), 32'(exp_b));
        @(negedge CLK);
        check({tag, "_idle_ready"}, 32'(IN_READY), 32'd1);
        check({tag, "_idle_ovalid"}, 32'(OUT_VALID), 32'd0);
    endtask

    initial begin
        int n;
        int issued;
        int received;
        int cycles;
        logic [4:0] exp_q[$];
        logic [4:0] exp_v;

        RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; BIN = 1'b0; OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_diff", 32'(DIFF), 32'd0);
        check("rst_bout", 32'(BOUT), 32'd0);

        // Directed vectors
        run_op("v0", 4'b0101, 4'b0000, 1'b0, 4'b0101, 1'b0);
        run_op("v1", 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1);
        run_op("v2", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1);
        run_op("v3", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
        run_op("v4", 4'b1001, 4'b0110, 1'b1, 4'b0010, 1'b0);

        // Back-pressure: 6 - 3 - 0 = 3, held for 3 cycles with input noise
        @(negedge CLK);
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; A = 4'b0110; B = 4'b0011; BIN = 1'b0;
        @(negedge CLK);
        IN_VALID = 1'b0;
        n = 0;
        while (!OUT_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("bp_latency", 32'(n), 32'd4);
        for (int i = 0; i < 3; i++) begin
            IN_VALID = i[0]; A = 4'(i * 5); B = 4'(15 - i); BIN = ~i[0];
            @(negedge CLK);
            check("bp_ovalid", 32'(OUT_VALID), 32'd1);
            check("bp_diff", 32'(DIFF), 32'd3);
            check("bp_bout", 32'(BOUT), 32'd0);
            check("bp_in_ready", 32'(IN_READY), 32'd0);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("bp_release_ready", 32'(IN_READY), 32'd1);
        check("bp_release_ovalid", 32'(OUT_VALID), 32'd0);

        // Reset on the 2nd RUN bit aborts the operation
        IN_VALID = 1'b1; A = 4'b1010; B = 4'b0001; BIN = 1'b0;
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_in_ready", 32'(IN_READY), 32'd1);
        check("abort_ovalid", 32'(OUT_VALID), 32'd0);
        check("abort_diff", 32'(DIFF), 32'd0);
        check("abort_bout", 32'(BOUT), 32'd0);
        repeat (6) @(negedge CLK);
        check("abort_no_result", 32'(OUT_VALID), 32'd0);
        run_op("post_abort", 4'b1100, 4'b0101, 1'b1, 4'b0110, 1'b0);

        // Exhaustive: producer always offers the next set, consumer stalls randomly
        issued = 0; received = 0; cycles = 0;
        @(negedge CLK);
        while (received < 512 && cycles < 20000) begin
            OUT_READY = ($urandom_range(0, 3) != 0);
            if (OUT_VALID && OUT_READY) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1f;
                check("exh_result", 32'({BOUT, DIFF}), 32'(exp_v));
                received++;
            end
            if (issued < 512) begin
                IN_VALID = 1'b1;
                A   = 4'(issued >> 5);
                B   = 4'(issued >> 1);
                BIN = issued[0];
                if (IN_READY) begin
                    exp_q.push_back({1'b0, A} - {1'b0, B} - {4'b0, BIN});
                    issued++;
                end
            end else begin
                IN_VALID = 1'b0;
            end
            @(negedge CLK);
            cycles++;
        end
        check("exh_count", 32'(received), 32'd512);
        IN_VALID = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_sub_nbit.md
# serial_sub_nbit

Bit-serial WIDTH-bit subtractor with borrow-in/borrow-out, the inverse-direction companion to the team's ripple-carry adder. It computes DIFF = A − B − BIN one bit per cycle, LSB first, through a single full-subtractor stage and a borrow flip-flop. Operands enter and results leave over valid/ready handshakes, so the block sits between an operand producer and a result consumer in an area-constrained datapath.

## Interface
- WIDTH, 4, operand/result width in bits (≥ 2)
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- IN_VALID  input  1  operand set A/B/BIN valid
- IN_READY  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- BIN  input  1  borrow-in
- OUT_VALID  output  1  DIFF/BOUT valid
- OUT_READY  input  1  consumer accepts result
- DIFF  output  WIDTH  (A − B − BIN) mod 2^WIDTH
- BOUT  output  1  borrow-out, 1 iff A < B + BIN (unsigned)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: IN_READY = 1, OUT_VALID = 0. On IN_VALID && IN_READY, capture A and B into shift registers, load borrow register with BIN, clear bit counter, and go to RUN.
- RUN: each cycle, take a0 = A_sh[0] and b0 = B_sh[0].
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into DIFF at the MSB, shifting right.
  - Shift A_sh and B_sh right.
  - Increment the counter. After the WIDTH-th bit, go to DONE.
- DONE: OUT_VALID = 1. DIFF and BOUT (= final borrow) are held stable. On OUT_VALID && OUT_READY, go to IDLE.
- Operand inputs are ignored outside the IDLE accept cycle. Changes on A/B/BIN during RUN or DONE have no effect.
- IN_VALID while in RUN or DONE is ignored, because IN_READY = 0. The producer must hold its operands until accepted.
- The DIFF/BOUT registers retain their last result in IDLE. They are meaningful only while OUT_VALID = 1.
- All arithmetic is unsigned modulo 2^WIDTH. There are no overflow flags; signed interpretation is left to the caller.

## Timing
- Reset values: IN_READY = 1 (state IDLE), OUT_VALID = 0, DIFF = 0, BOUT = 0. Counter, shift registers and borrow register are all 0.
- Latency: if operands are accepted at edge k, RUN occupies edges k+1 … k+WIDTH, and OUT_VALID rises after edge k+WIDTH. For WIDTH = 4, the result is visible 4 cycles after acceptance.
- Result acceptance at edge m means IN_READY = 1 from edge m onward. The next operand can be accepted at edge m+1 at the earliest; there is no same-cycle bypass.
- Minimum initiation interval is WIDTH+2 cycles.
- Back-pressure: OUT_READY low holds DONE indefinitely, with outputs stable.
- RST asserted in any state returns to IDLE with reset values on the next edge.
  - A reset in RUN aborts the operation; no OUT_VALID is ever produced for it.
  - RST has priority over a simultaneous handshake.
- IN_READY and OUT_VALID are decoded from the state register only. They have no combinational path from IN_VALID or OUT_READY.

## Structure
- Package serial_sub_pkg:
  - state enum {IDLE, RUN, DONE}
  - default WIDTH constant
  - counter-width function $clog2(WIDTH+1)
- Sub-module full_subtractor: purely combinational 1-bit cell (a, b, bin → d, bout), instantiated once. It is verifiable standalone over all 8 input combinations.
- Top level holds the FSM, counter, shift registers, borrow register and output registers.

## Test plan
- Reset, then A=0101, B=0000, BIN=0 with OUT_READY=1 → OUT_VALID rises 4 cycles after accept; DIFF=0101, BOUT=0; IN_READY=1 the cycle after result handoff.
- A=0011, B=0101, BIN=0 → DIFF=1110, BOUT=1. A=0000, B=0000, BIN=1 → DIFF=1111, BOUT=1.
- A=1111, B=1111, BIN=1 → DIFF=1111, BOUT=1. A=1001, B=0110, BIN=1 → DIFF=0010, BOUT=0.
- Back-pressure: hold OUT_READY=0 for 3 cycles in DONE → OUT_VALID, DIFF and BOUT stay constant. Toggling A/B/IN_VALID meanwhile has no effect. Result accepted on the first cycle OUT_READY=1.
- Assert RST for one cycle during RUN, on the 2nd bit → next cycle IN_READY=1, OUT_VALID=0, DIFF=0, BOUT=0. A new operation afterwards completes correctly.
- Exhaustive: all 16×16×2 = 512 (A, B, BIN) combinations, back-to-back at minimum initiation interval, with random OUT_READY stalls. Each result is checked against a reference model {BOUT, DIFF} = {1'b0, A} − B − BIN.
